// File: rtl/sonata_clkgen.sv
// sonata_clkgen: board clock/reset generator for the Sonata system top.
//
// Buffers the board clock and derives the system clock from it. Once the clock
// source has been seen locked for LockCycles consecutive IO_CLK cycles, it releases
// an active-low system reset. That release is synchronised to clk_sys and then
// stretched by RstStretch cycles.
//
// Build option: define CLKGEN_PLL_EN to generate clk_sys with a PLLE2_BASE (50 MHz from
// 25 MHz) and BUFG buffering. Leave it undefined for the portable 1:1 build, where
// clk_sys = IO_CLK and the lock source is tied high.
//
// Ports:
//   IO_CLK      in   board clock (25 MHz)
//   IO_RST      in   asynchronous active-high reset
//   IO_CLK_BUF  out  buffered copy of IO_CLK
//   clk_sys     out  system clock
//   rst_sys_n   out  system reset, active low; async assert, sync deassert to clk_sys
//   locked_o    out  clock qualified as locked (IO_CLK domain register)
module sonata_clkgen #(
    parameter int unsigned LockCycles = 64,
    parameter int unsigned SyncStages = 2,
    parameter int unsigned RstStretch = 16
) (
    input  logic IO_CLK,
    input  logic IO_RST,
    output logic IO_CLK_BUF,
    output logic clk_sys,
    output logic rst_sys_n,
    output logic locked_o
);

    localparam int unsigned LockW    = $clog2(LockCycles + 1);
    localparam int unsigned StretchW = $clog2(RstStretch + 1);
    localparam logic [LockW-1:0]    LockMax    = LockW'(LockCycles);
    localparam logic [StretchW-1:0] StretchMax = StretchW'(RstStretch);

    logic w_pll_lock;

`ifdef CLKGEN_PLL_EN
    logic       w_clk_fb;
    logic       w_clk_pll;
    logic       w_pll_locked_raw;
    logic [1:0] r_lock_sync;

    BUFG u_bufg_io (.I(IO_CLK), .O(IO_CLK_BUF));

    // VCO = 25 MHz * 40 = 1000 MHz; CLKOUT0 = 1000 / 20 = 50 MHz.
    PLLE2_BASE #(
        .CLKIN1_PERIOD  (40.0),
        .DIVCLK_DIVIDE  (1),
        .CLKFBOUT_MULT  (40),
        .CLKOUT0_DIVIDE (20)
    ) u_pll (
        .CLKIN1   (IO_CLK),
        .CLKFBIN  (w_clk_fb),
        .CLKFBOUT (w_clk_fb),
        .CLKOUT0  (w_clk_pll),
        .CLKOUT1  (),
        .CLKOUT2  (),
        .CLKOUT3  (),
        .CLKOUT4  (),
        .CLKOUT5  (),
        .LOCKED   (w_pll_locked_raw),
        .PWRDWN   (1'b0),
        .RST      (IO_RST)
    );

    BUFG u_bufg_sys (.I(w_clk_pll), .O(clk_sys));

    // LOCKED is asynchronous to IO_CLK.
    always_ff @(posedge IO_CLK or posedge IO_RST) begin
        if (IO_RST) begin
            r_lock_sync <= 2'b00;
        end else begin
            r_lock_sync <= {r_lock_sync[0], w_pll_locked_raw};
        end
    end

    assign w_pll_lock = r_lock_sync[1];
`else
    assign IO_CLK_BUF = IO_CLK;
    assign clk_sys    = IO_CLK;
    assign w_pll_lock = 1'b1;
`endif

    // ---------------- Lock qualification (IO_CLK domain) ----------------
    logic [LockW-1:0] r_lock_cnt;
    logic [LockW-1:0] w_lock_cnt_d;
    logic             r_locked;

    always_comb begin
        w_lock_cnt_d = r_lock_cnt;
        if (!w_pll_lock) begin
            w_lock_cnt_d = '0;
        end else if (r_lock_cnt != LockMax) begin
            w_lock_cnt_d = r_lock_cnt + LockW'(1);
        end
    end

    // locked is registered from the next count, so it rises on the edge that
    // brings the count to LockCycles.
    always_ff @(posedge IO_CLK or posedge IO_RST) begin
        if (IO_RST) begin
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
        end else begin
            r_lock_cnt <= w_lock_cnt_d;
            r_locked   <= (w_lock_cnt_d == LockMax);
        end
    end

    assign locked_o = r_locked;

    // ---------------- Reset release (clk_sys domain) ----------------
    // Both operands come from a pin or a flop, so this async clear is glitch-free.
    logic w_rel_rst;
    assign w_rel_rst = IO_RST | ~r_locked;

    logic [SyncStages-1:0] r_sync;
    logic [StretchW-1:0]   r_stretch_cnt;
    logic [StretchW-1:0]   w_stretch_d;
    logic                  r_rst_sys_n;

    always_ff @(posedge clk_sys or posedge w_rel_rst) begin
        if (w_rel_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SyncStages-2:0], 1'b1};
        end
    end

    always_comb begin
        w_stretch_d = r_stretch_cnt;
        if (r_sync[SyncStages-1] && (r_stretch_cnt != StretchMax)) begin
            w_stretch_d = r_stretch_cnt + StretchW'(1);
        end
    end

    always_ff @(posedge clk_sys or posedge w_rel_rst) begin
        if (w_rel_rst) begin
            r_stretch_cnt <= '0;
            r_rst_sys_n   <= 1'b0;
        end else begin
            r_stretch_cnt <= w_stretch_d;
            r_rst_sys_n   <= (w_stretch_d == StretchMax);
        end
    end

    assign rst_sys_n = r_rst_sys_n;

endmodule

// File: tb/tb_sonata_clkgen.sv
`timescale 1ns/1ps
module tb_sonata_clkgen;

    logic clk;
    logic rst_a;
    logic rst_b;
    logic buf_a, sys_a, rstn_a, lock_a;
    logic buf_b, sys_b, rstn_b, lock_b;

    int n_checks = 0;
    int n_pass   = 0;
    int q_exp[$];

    sonata_clkgen u_dut_a (
        .IO_CLK     (clk),
        .IO_RST     (rst_a),
        .IO_CLK_BUF (buf_a),
        .clk_sys    (sys_a),
        .rst_sys_n  (rstn_a),
        .locked_o   (lock_a)
    );

    sonata_clkgen #(
        .LockCycles (1),
        .SyncStages (2),
        .RstStretch (1)
    ) u_dut_b (
        .IO_CLK     (clk),
        .IO_RST     (rst_b),
        .IO_CLK_BUF (buf_b),
        .clk_sys    (sys_b),
        .rst_sys_n  (rstn_b),
        .locked_o   (lock_b)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Both clock outputs must follow IO_CLK through every edge.
    always @(clk) begin
        #1;
        check("clk_buf_a", int'(buf_a), int'(clk));
        check("clk_sys_a", int'(sys_a), int'(clk));
        check("clk_buf_b", int'(buf_b), int'(clk));
        check("clk_sys_b", int'(sys_b), int'(clk));
    end

    // Call with reset just released, before the next rising edge (edge 1).
    // Pushes the expected rise edges, then pops them as the DUT produces them.
    task automatic measure(input bit sel, input int exp_lock, input int exp_rst);
        int lock_edge;
        int rst_edge;
        logic lk;
        logic rn;
        lock_edge = -1;
        rst_edge  = -1;
        q_exp.push_back(exp_lock);
        q_exp.push_back(exp_rst);
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            lk = sel ? lock_b : lock_a;
            rn = sel ? rstn_b : rstn_a;
            if (lk && lock_edge < 0) lock_edge = n;
            if (rn && rst_edge < 0) begin
                rst_edge = n;
                break;
            end
        end
        check(sel ? "lock_edge_b" : "lock_edge_a", lock_edge, q_exp.pop_front());
        check(sel ? "rst_edge_b" : "rst_edge_a", rst_edge, q_exp.pop_front());
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("rst_hold_locked", int'(lock_a), 0);
        check("rst_hold_rstn", int'(rstn_a), 0);
        check("rst_hold_locked_b", int'(lock_b), 0);
        check("rst_hold_rstn_b", int'(rstn_b), 0);

        // Normal release: locked after edge 64, rst_sys_n after edge 82.
        @(negedge clk);
        rst_a = 1'b0;
        measure(1'b0, 64, 82);

        // IO_RST while rst_sys_n=1: must drop before the next clock edge.
        #9;
        rst_a = 1'b1;
        #1;
        check("async_rstn", int'(rstn_a), 0);
        check("async_locked", int'(lock_a), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0;

        // Short pulse mid-count at edge 70, then the full latency again.
        for (int n = 1; n <= 70; n++) begin
            @(posedge clk);
        end
        #1;
        check("mid_locked_before", int'(lock_a), 1);
        check("mid_rstn_before", int'(rstn_a), 0);
        #4;
        rst_a = 1'b1;
        #1;
        check("pulse_rstn", int'(rstn_a), 0);
        check("pulse_locked", int'(lock_a), 0);
        #2;
        rst_a = 1'b0;
        measure(1'b0, 64, 82);

        // Minimal parameter set: rst_sys_n after edge 4.
        @(negedge clk);
        rst_b = 1'b0;
        measure(1'b1, 1, 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
